issue_dispatch_queue: RTL

Instruction buffer and dual-issue dispatcher between fetch and the two decode slots. Accepts up to two fetched instructions per cycle into a circular queue. Each cycle it dispatches up to two in program order: load/store to the memory slot, branch/jump to the branch slot, ALU to either. Its registered outputs are the issue-stage instructions watched by the load-use hazard logic, and it holds on that logic's stall.

---
 rtl/issue_pkg.sv | 29 ++
 rtl/issue_classify.sv | 49 ++++
 rtl/issue_dispatch_queue.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/issue_pkg.sv
// ---------------------------------------------------------------------------
// issue_pkg
// Definitions shared by the issue/dispatch queue and its classifier:
//   - RV32 opcode constants used for slot steering and register-use decode
//   - NOP encoding driven into empty issue slots (addi x0,x0,0)
//   - slot_class_t : which issue slot an instruction needs
//   - entry_t      : one queue entry {instr, pc}
// ---------------------------------------------------------------------------
package issue_pkg;

   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [31:0] NOP = 32'h0000_0013;

   typedef enum logic [1:0] {CLS_ALU, CLS_MEM, CLS_CTRL} slot_class_t;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
   } entry_t;

endpackage

// File: rtl/issue_classify.sv
// ---------------------------------------------------------------------------
// issue_classify
// Combinational decode of one instruction for dispatch decisions.
// Ports:
//   instr_i      in  32  instruction word
//   cls_o        out     issue slot class (ALU / MEM / CTRL)
//   reads_rs1_o  out  1  rs1 is a real source operand
//   reads_rs2_o  out  1  rs2 is a real source operand
//   writes_rd_o  out  1  rd is written and is not x0
//   rs1_o/rs2_o/rd_o out 5 register fields
// ---------------------------------------------------------------------------
module issue_classify
   import issue_pkg::*;
(
   input  logic [31:0] instr_i,
   output slot_class_t cls_o,
   output logic        reads_rs1_o,
   output logic        reads_rs2_o,
   output logic        writes_rd_o,
   output logic [4:0]  rs1_o,
   output logic [4:0]  rs2_o,
   output logic [4:0]  rd_o
);

   logic [6:0] opc;
   logic       unused_bits;

   assign opc   = instr_i[6:0];
   assign rd_o  = instr_i[11:7];
   assign rs1_o = instr_i[19:15];
   assign rs2_o = instr_i[24:20];
   assign unused_bits = ^{instr_i[31:25], instr_i[14:12]};

   // NOTE: every combinational output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      cls_o = CLS_ALU;
      if (opc == OPC_LOAD || opc == OPC_STORE) begin
         cls_o = CLS_MEM;
      end else if (opc == OPC_BRANCH || opc == OPC_JAL || opc == OPC_JALR) begin
         cls_o = CLS_CTRL;
      end
   end

   assign reads_rs1_o = !(opc == OPC_LUI || opc == OPC_AUIPC || opc == OPC_JAL);
   assign reads_rs2_o = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);
   assign writes_rd_o = !(opc == OPC_STORE || opc == OPC_BRANCH) && (rd_o != 5'd0);

endmodule

// File: rtl/issue_dispatch_queue.sv
// ---------------------------------------------------------------------------
// issue_dispatch_queue
// Circular instruction buffer between fetch and the two issue slots. Takes up
// to two instructions per cycle and dispatches up to two in program order:
// memory ops to the ls slot, control transfers to the bra slot, ALU ops to
// whichever slot is free. Issue outputs are registered and hold on stall_i.
// Optional feature: define ISSUE_PERF_CNT_EN to add perf_dual_o,
// perf_single_o and perf_stall_o saturating counters.
// Ports:
//   clk_i, rst_i (sync, active-high)
//   fetch_instr0_i/fetch_instr1_i, fetch_pc0_i/fetch_pc1_i,
//   fetch_valid0_i/fetch_valid1_i  fetch pair (slot 0 older)
//   fetch_ready_o                  room for two entries
//   stall_i                        hazard-unit stall
//   flush_i                        redirect; empties queue and slots
//   instr/pc/valid _ls_iss_o       memory-slot issue register
//   instr/pc/valid _bra_iss_o      branch-slot issue register
// ---------------------------------------------------------------------------
module issue_dispatch_queue
   import issue_pkg::*;
#(
   parameter int DEPTH = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic [31:0] fetch_instr0_i,
   input  logic [31:0] fetch_instr1_i,
   input  logic [31:0] fetch_pc0_i,
   input  logic [31:0] fetch_pc1_i,
   input  logic        fetch_valid0_i,
   input  logic        fetch_valid1_i,
   output logic        fetch_ready_o,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic [31:0] instr_ls_iss_o,
   output logic [31:0] pc_ls_iss_o,
   output logic [31:0] instr_bra_iss_o,
   output logic [31:0] pc_bra_iss_o,
   output logic        valid_ls_iss_o,
   output logic        valid_bra_iss_o
`ifdef ISSUE_PERF_CNT_EN
   ,
   output logic [31:0] perf_dual_o,
   output logic [31:0] perf_single_o,
   output logic [31:0] perf_stall_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   entry_t             mem [DEPTH];
   logic [PTR_W-1:0]   rd_ptr, wr_ptr;
   logic [CNT_W-1:0]   count;
   logic [1:0]         push_cnt, pop_cnt;
   logic               clear;

   entry_t             h, h1, ls_q, bra_q;
   logic               ls_v_q, bra_v_q;

   slot_class_t        h_cls, h1_cls;
   logic               h_rs1r, h_rs2r, h_wr, h1_rs1r, h1_rs2r, h1_wr;
   logic [4:0]         h_rs1, h_rs2, h_rd, h1_rs1, h1_rs2, h1_rd;
   logic               unused_h;
   logic               pair_ok, h_to_bra;

   assign clear         = rst_i || flush_i;
   assign fetch_ready_o = (CNT_W'(DEPTH) - count) >= CNT_W'(2);
   assign push_cnt      = (fetch_ready_o && fetch_valid0_i) ? (fetch_valid1_i ? 2'd2 : 2'd1) : 2'd0;

   assign h  = mem[rd_ptr];
   assign h1 = mem[rd_ptr + PTR_W'(1)];

   issue_classify u_cls_h (
      .instr_i     (h.instr),
      .cls_o       (h_cls),
      .reads_rs1_o (h_rs1r),
      .reads_rs2_o (h_rs2r),
      .writes_rd_o (h_wr),
      .rs1_o       (h_rs1),
      .rs2_o       (h_rs2),
      .rd_o        (h_rd)
   );

   issue_classify u_cls_h1 (
      .instr_i     (h1.instr),
      .cls_o       (h1_cls),
      .reads_rs1_o (h1_rs1r),
      .reads_rs2_o (h1_rs2r),
      .writes_rd_o (h1_wr),
      .rs1_o       (h1_rs1),
      .rs2_o       (h1_rs2),
      .rd_o        (h1_rd)
   );

   // The head's own sources never matter for pairing; only the younger one's do.
   assign unused_h = ^{h_rs1r, h_rs2r, h_rs1, h_rs2};

   // Pairing: H must not be a control transfer, both cannot need the ls slot,
   // and H1 may neither consume nor overwrite H's destination.
   always_comb begin
      pair_ok = (count >= CNT_W'(2)) && (h_cls != CLS_CTRL)
             && !(h_cls == CLS_MEM && h1_cls == CLS_MEM)
             && !(h_wr && h1_rs1r && (h1_rs1 == h_rd))
             && !(h_wr && h1_rs2r && (h1_rs2 == h_rd))
             && !(h_wr && h1_wr && (h1_rd == h_rd));
      pop_cnt  = 2'd0;
      h_to_bra = 1'b0;
      if (!stall_i && count != '0) begin
         pop_cnt  = pair_ok ? 2'd2 : 2'd1;
         // An ALU head yields the ls slot when it is paired with a memory op.
         h_to_bra = (h_cls == CLS_CTRL) || (pair_ok && h_cls == CLS_ALU && h1_cls == CLS_MEM);
      end
   end

   // NOTE: the entry storage is deliberately not reset; count and the pointers
   // define which entries are live, so stale contents are never observed.
   always_ff @(posedge clk_i) begin
      if (!clear) begin
         if (push_cnt != 2'd0) mem[wr_ptr] <= '{instr: fetch_instr0_i, pc: fetch_pc0_i};
         if (push_cnt == 2'd2) mem[wr_ptr + PTR_W'(1)] <= '{instr: fetch_instr1_i, pc: fetch_pc1_i};
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (clear) begin
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
         ls_q    <= '{instr: NOP, pc: 32'h0};
         bra_q   <= '{instr: NOP, pc: 32'h0};
         ls_v_q  <= 1'b0;
         bra_v_q <= 1'b0;
      end else begin
         wr_ptr <= wr_ptr + PTR_W'(push_cnt);
         rd_ptr <= rd_ptr + PTR_W'(pop_cnt);
         count  <= count + CNT_W'(push_cnt) - CNT_W'(pop_cnt);
         if (!stall_i) begin
            ls_q    <= '{instr: NOP, pc: 32'h0};
            bra_q   <= '{instr: NOP, pc: 32'h0};
            ls_v_q  <= 1'b0;
            bra_v_q <= 1'b0;
            if (pop_cnt != 2'd0) begin
               if (h_to_bra) begin
                  bra_q   <= h;
                  bra_v_q <= 1'b1;
               end else begin
                  ls_q    <= h;
                  ls_v_q  <= 1'b1;
               end
            end
            // A co-issued H1 always lands in the slot H left free.
            if (pop_cnt == 2'd2) begin
               if (h_to_bra) begin
                  ls_q    <= h1;
                  ls_v_q  <= 1'b1;
               end else begin
                  bra_q   <= h1;
                  bra_v_q <= 1'b1;
               end
            end
         end
      end
   end

   assign instr_ls_iss_o  = ls_q.instr;
   assign pc_ls_iss_o     = ls_q.pc;
   assign valid_ls_iss_o  = ls_v_q;
   assign instr_bra_iss_o = bra_q.instr;
   assign pc_bra_iss_o    = bra_q.pc;
   assign valid_bra_iss_o = bra_v_q;

`ifdef ISSUE_PERF_CNT_EN
   // Performance counters survive flush; only reset clears them.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_dual_o   <= '0;
         perf_single_o <= '0;
         perf_stall_o  <= '0;
      end else begin
         if (!flush_i && pop_cnt == 2'd2 && perf_dual_o != '1) perf_dual_o <= perf_dual_o + 32'd1;
         if (!flush_i && pop_cnt == 2'd1 && perf_single_o != '1) perf_single_o <= perf_single_o + 32'd1;
         if (stall_i && count != '0 && perf_stall_o != '1) perf_stall_o <= perf_stall_o + 32'd1;
      end
   end
`endif

endmodule
